// File: rtl/riscv_test_monitor.sv
// riscv_test_monitor
//
// End-of-test monitor for an RV32I core running riscv-tests. Watches the core
// PC for the halt address and decodes the riscv-tests gp (x3) convention into
// sticky pass / fail / timeout flags plus the failing test number.
//
// Parameters:
//   HALT_PC  PC value that marks test completion
//   TIMEOUT  cycles spent in RUN before a timeout is declared (>= 1)
//
// Ports:
//   clk              clock, rising edge
//   rst              asynchronous active-high reset
//   clear            synchronous restart back to RUN, counters zeroed
//   pc, gp           core program counter and x3, sampled every edge
//   done             any terminal state reached
//   pass/fail/timeout  one-hot terminal outcome while done is high
//   test_num         gp[31:1] latched at a failing halt, else 0
//   cycle_count      (TEST_MONITOR_PERF_EN only) RUN edges seen
//   pc_change_count  (TEST_MONITOR_PERF_EN only) RUN edges where pc changed
//
// Build option: define TEST_MONITOR_PERF_EN to add the two perf counters.
//
// state   | meaning
// --------+-------------------------------------------------
// RUN     | test executing, tick counter advancing
// PASS    | halt reached with gp == 1 (sticky)
// FAIL    | halt reached with gp != 1, test_num latched (sticky)
// TIMEOUT | TIMEOUT edges elapsed without halt (sticky)

module riscv_test_monitor #(
    parameter logic [31:0] HALT_PC = 32'h44,
    parameter int unsigned TIMEOUT = 5000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic [31:0] pc,
    input  logic [31:0] gp,
    output logic        done,
    output logic        pass,
    output logic        fail,
    output logic        timeout,
    output logic [30:0] test_num
`ifdef TEST_MONITOR_PERF_EN
    ,
    output logic [31:0] cycle_count,
    output logic [31:0] pc_change_count
`endif
);

    localparam logic [1:0] ST_RUN     = 2'd0;
    localparam logic [1:0] ST_PASS    = 2'd1;
    localparam logic [1:0] ST_FAIL    = 2'd2;
    localparam logic [1:0] ST_TIMEOUT = 2'd3;

    localparam int unsigned TICK_W = $clog2(TIMEOUT + 1);
    // The counter stops at this value, so it can never wrap.
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TIMEOUT - 1);

    logic [1:0]        state_q, state_d;
    logic [TICK_W-1:0] tick_q, tick_d;
    logic [30:0]       test_num_q, test_num_d;
    logic              halt_hit;

    assign halt_hit = (pc == HALT_PC);

    always_comb begin
        state_d    = state_q;
        tick_d     = tick_q;
        test_num_d = test_num_q;
        // clear outranks everything, including a halt on the same edge
        if (clear) begin
            state_d    = ST_RUN;
            tick_d     = '0;
            test_num_d = '0;
        end else if (state_q == ST_RUN) begin
            // halt is checked before expiry so a coincident halt wins
            if (halt_hit && gp == 32'd1) begin
                state_d = ST_PASS;
            end else if (halt_hit) begin
                state_d    = ST_FAIL;
                test_num_d = gp[31:1];
            end else if (tick_q == TICK_LAST) begin
                state_d = ST_TIMEOUT;
            end else begin
                tick_d = tick_q + TICK_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_RUN;
            tick_q     <= '0;
            test_num_q <= '0;
        end else begin
            state_q    <= state_d;
            tick_q     <= tick_d;
            test_num_q <= test_num_d;
        end
    end

    // Decoded straight from the state register; asynchronous reset clears
    // them immediately.
    assign done     = (state_q != ST_RUN);
    assign pass     = (state_q == ST_PASS);
    assign fail     = (state_q == ST_FAIL);
    assign timeout  = (state_q == ST_TIMEOUT);
    assign test_num = test_num_q;

`ifdef TEST_MONITOR_PERF_EN
    logic [31:0] cycle_count_q, cycle_count_d;
    logic [31:0] pc_change_count_q, pc_change_count_d;
    logic [31:0] pc_q, pc_d;
    logic        run_edge;

    assign run_edge = (state_q == ST_RUN) && !clear;

    always_comb begin
        cycle_count_d     = cycle_count_q;
        pc_change_count_d = pc_change_count_q;
        pc_d              = pc;
        if (clear) begin
            cycle_count_d     = '0;
            pc_change_count_d = '0;
            pc_d              = '0;
        end else if (run_edge) begin
            cycle_count_d = cycle_count_q + 32'd1;
            if (pc != pc_q) begin
                pc_change_count_d = pc_change_count_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycle_count_q     <= '0;
            pc_change_count_q <= '0;
            pc_q              <= '0;
        end else begin
            cycle_count_q     <= cycle_count_d;
            pc_change_count_q <= pc_change_count_d;
            pc_q              <= pc_d;
        end
    end

    assign cycle_count     = cycle_count_q;
    assign pc_change_count = pc_change_count_q;
`endif

endmodule

// File: tb/tb_riscv_test_monitor.sv
module tb_riscv_test_monitor;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clear = 1'b0;
    logic [31:0] pc = 32'h0;
    logic [31:0] gp = 32'h0;

    logic        done_a, pass_a, fail_a, timeout_a;
    logic [30:0] test_num_a;
    logic        done_b, pass_b, fail_b, timeout_b;
    logic [30:0] test_num_b;
`ifdef TEST_MONITOR_PERF_EN
    logic [31:0] cyc_a, pcc_a, cyc_b, pcc_b;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    riscv_test_monitor u_dut (
        .clk(clk), .rst(rst), .clear(clear), .pc(pc), .gp(gp),
        .done(done_a), .pass(pass_a), .fail(fail_a), .timeout(timeout_a),
        .test_num(test_num_a)
`ifdef TEST_MONITOR_PERF_EN
        , .cycle_count(cyc_a), .pc_change_count(pcc_a)
`endif
    );

    riscv_test_monitor #(.HALT_PC(32'h44), .TIMEOUT(8)) u_dut_t8 (
        .clk(clk), .rst(rst), .clear(clear), .pc(pc), .gp(gp),
        .done(done_b), .pass(pass_b), .fail(fail_b), .timeout(timeout_b),
        .test_num(test_num_b)
`ifdef TEST_MONITOR_PERF_EN
        , .cycle_count(cyc_b), .pc_change_count(pcc_b)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // advance one edge, leave time 1ns after it for driving and sampling
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // reset pulse fully between edges
    task automatic pulse_rst();
        rst = 1'b1;
        #2;
        rst = 1'b0;
    endtask

    initial begin
        // reset state
        #2;
        chk("rst_done", {31'd0, done_a}, 32'd0);
        chk("rst_flags", {29'd0, pass_a, fail_a, timeout_a}, 32'd0);
        chk("rst_test_num", {1'b0, test_num_a}, 32'd0);
`ifdef TEST_MONITOR_PERF_EN
        chk("rst_cyc", cyc_a, 32'd0);
        chk("rst_pcc", pcc_a, 32'd0);
`endif
        step(1);
        rst = 1'b0;

        // pass: 20 cycles at 0x10, then halt with gp=1
        pc = 32'h10; gp = 32'h0;
        step(20);
        chk("pass_pre_done", {31'd0, done_a}, 32'd0);
        pc = 32'h44; gp = 32'h1;
        step(1);
        chk("pass_done", {31'd0, done_a}, 32'd1);
        chk("pass_flags", {29'd0, pass_a, fail_a, timeout_a}, 32'b100);
`ifdef TEST_MONITOR_PERF_EN
        chk("pass_cyc", cyc_a, 32'd21);
        chk("pass_pcc", pcc_a, 32'd2);
`endif
        pc = 32'h80; gp = 32'h7;
        step(3);
        chk("pass_sticky", {29'd0, pass_a, fail_a, timeout_a}, 32'b100);
`ifdef TEST_MONITOR_PERF_EN
        chk("pass_cyc_frozen", cyc_a, 32'd21);
`endif

        // fail: gp=0xB -> test 5, flags stay while inputs move
        pulse_rst();
        pc = 32'h44; gp = 32'h0000_000B;
        step(1);
        chk("fail_flags", {28'd0, done_a, pass_a, fail_a, timeout_a}, 32'b1010);
        chk("fail_test_num", {1'b0, test_num_a}, 32'd5);
        pc = 32'h44; gp = 32'h1;
        step(1);
        pc = 32'h20; gp = 32'h3;
        step(1);
        chk("fail_sticky", {28'd0, done_a, pass_a, fail_a, timeout_a}, 32'b1010);
        chk("fail_test_num_stable", {1'b0, test_num_a}, 32'd5);

        // clear race: clear beats a simultaneous passing halt
        clear = 1'b1; pc = 32'h44; gp = 32'h1;
        step(1);
        chk("clr_flags", {28'd0, done_a, pass_a, fail_a, timeout_a}, 32'b0000);
        chk("clr_test_num", {1'b0, test_num_a}, 32'd0);
`ifdef TEST_MONITOR_PERF_EN
        chk("clr_cyc", cyc_a, 32'd0);
`endif
        clear = 1'b0;
        step(1);
        chk("clr_then_pass", {28'd0, done_a, pass_a, fail_a, timeout_a}, 32'b1100);
`ifdef TEST_MONITOR_PERF_EN
        chk("clr_then_cyc", cyc_a, 32'd1);
`endif

        // gp with bit0 clear is a fail; high test number bits kept
        clear = 1'b1;
        step(1);
        clear = 1'b0; pc = 32'h44; gp = 32'hFFFF_FFFE;
        step(1);
        chk("gp_even_fail", {29'd0, pass_a, fail_a, timeout_a}, 32'b010);
        chk("gp_even_num", {1'b0, test_num_a}, 32'h7FFF_FFFF);
        clear = 1'b1;
        step(1);
        clear = 1'b0; gp = 32'h0;
        step(1);
        chk("gp_zero_fail", {29'd0, pass_a, fail_a, timeout_a}, 32'b010);
        chk("gp_zero_num", {1'b0, test_num_a}, 32'd0);

        // timeout with TIMEOUT=8
        pulse_rst();
        pc = 32'h10; gp = 32'h0;
        step(7);
        chk("to_edge7", {28'd0, done_b, pass_b, fail_b, timeout_b}, 32'b0000);
        step(1);
        chk("to_edge8", {28'd0, done_b, pass_b, fail_b, timeout_b}, 32'b1001);
        pc = 32'h44; gp = 32'h1;
        step(1);
        chk("to_sticky", {28'd0, done_b, pass_b, fail_b, timeout_b}, 32'b1001);

        // halt on exactly the 8th edge wins over timeout
        pulse_rst();
        pc = 32'h10; gp = 32'h0;
        step(7);
        pc = 32'h44; gp = 32'h1;
        step(1);
        chk("race_flags", {28'd0, done_b, pass_b, fail_b, timeout_b}, 32'b1100);

        // async reset between edges clears terminal outputs immediately
        chk("ar_pre", {30'd0, pass_a, pass_b}, 32'b11);
        rst = 1'b1;
        #1;
        chk("ar_a", {28'd0, done_a, pass_a, fail_a, timeout_a}, 32'b0000);
        chk("ar_b", {28'd0, done_b, pass_b, fail_b, timeout_b}, 32'b0000);
        #1;
        rst = 1'b0;
        // mid-RUN async reset: run a few edges, reset, then toggle pc
        pc = 32'h10; gp = 32'h0;
        step(5);
        #2;
        rst = 1'b1;
        #1;
        chk("ar_run_a", {28'd0, done_a, pass_a, fail_a, timeout_a}, 32'b0000);
`ifdef TEST_MONITOR_PERF_EN
        chk("ar_run_cyc", cyc_a, 32'd0);
`endif
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            pc = (i % 2 == 0) ? 32'h4 : 32'h0;
            step(1);
        end
        chk("ar_after_run", {28'd0, done_a, pass_a, fail_a, timeout_a}, 32'b0000);
`ifdef TEST_MONITOR_PERF_EN
        chk("ar_pcc", pcc_a, 32'd10);
        chk("ar_cyc", cyc_a, 32'd10);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    // hard bound so the run always ends
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/riscv_test_monitor.md
# riscv_test_monitor

Synthesizable end-of-test monitor that sits directly downstream of the RV32I core. It samples the core's program counter and the `x3` (`gp`) register every cycle and detects arrival at the riscv-tests halt address. It then decodes the riscv-tests `gp` convention into sticky pass/fail/timeout flags and a failing test number. This replaces the bench-side PC polling and lets the same pass/fail result drive LEDs or a status register on FPGA.

## Interface
Parameters:
- `HALT_PC`, default `32'h44`: PC value that marks test completion.
- `TIMEOUT`, default `5000`: cycles in RUN before a timeout is declared. Must be ≥ 1.

Ports:
- `clk`, input, 1: clock. All state updates on the rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `clear`, input, 1: synchronous restart. Returns the block to RUN and zeroes the counters.
- `pc`, input, 32: core program counter, sampled every cycle.
- `gp`, input, 32: core register `x3`.
- `done`, output, 1: high once any terminal state is reached.
- `pass`, output, 1: halt reached with `gp == 1`.
- `fail`, output, 1: halt reached with `gp != 1`.
- `timeout`, output, 1: `TIMEOUT` cycles elapsed without reaching halt.
- `test_num`, output, 31: on fail, `gp[31:1]` as latched at halt. Otherwise 0.
- `cycle_count`, output, 32: present only with `TEST_MONITOR_PERF_EN`.
- `pc_change_count`, output, 32: present only with `TEST_MONITOR_PERF_EN`.

## Operation
- **States:** RUN, PASS, FAIL, TIMEOUT. PASS, FAIL and TIMEOUT are terminal and sticky until `rst` or `clear`.
- **Reset values:** state is RUN. `done`, `pass`, `fail`, `timeout` are 0. `test_num` is 0. The tick counter is 0. Perf counters are 0.
- **RUN behaviour:** on each edge,
  - if `pc == HALT_PC` and `gp == 32'd1`, go to PASS;
  - else if `pc == HALT_PC`, go to FAIL and latch `test_num <= gp[31:1]`;
  - else if tick counter `== TIMEOUT-1`, go to TIMEOUT;
  - else increment the tick counter.
- **Halt vs timeout:** a halt match on the same edge as timeout expiry wins.
- **Terminal states:** `pc` and `gp` are ignored. The tick counter freezes.
- **Outputs:** `done`, `pass`, `fail` and `timeout` are decoded from the state register with no extra pipeline. Exactly one of `pass`/`fail`/`timeout` is high when `done` is high.
- **`clear`:** has priority over every other transition, including a simultaneous halt match. The next state is RUN with counters at 0.
- **`gp` encoding:** a `gp` value with bit 0 clear but not equal to 1 (e.g. 0) still counts as FAIL, and `test_num` is `gp[31:1]`.
- **Counter width:** the tick counter is `$clog2(TIMEOUT+1)` bits wide and never wraps, because it stops at `TIMEOUT-1`.

## Timing
- **Halt latency:** `pc == HALT_PC` sampled at edge N gives `done` high after edge N, i.e. 1 cycle from the sample.
- **Timeout latency:** `timeout` rises after the `TIMEOUT`-th edge following reset release or `clear`. The first RUN edge counts as 1.
- **Reset mid-test:** `rst` asserted at any time, including in a terminal state, clears all outputs immediately (asynchronously). Counting restarts on the first edge after `rst` deasserts.
- **Flag stability:** `test_num` is stable for as long as FAIL holds.

## Configuration
- **Macro:** `TEST_MONITOR_PERF_EN`.
- **When defined:**
  - `cycle_count` increments on every edge in RUN.
  - `pc_change_count` increments on every RUN edge where `pc` differs from its value at the previous edge. It needs a 32-bit `pc_q` register, which resets to 0.
  - Both counters freeze in terminal states, zero on `rst`/`clear`, and wrap modulo 2^32.
- **When undefined:** both ports and all associated logic are absent. Behaviour otherwise is identical.

## Test plan
- **Pass:** reset, then hold `pc=0x10` for 20 cycles, then `pc=0x44` with `gp=1` → `done=1`, `pass=1` one cycle later. With perf enabled, `cycle_count=21`.
- **Fail:** `pc=0x44` with `gp=0x0000000B` → `fail=1`, `test_num=5`. Flags stay set while `pc` and `gp` change afterwards.
- **Timeout:** `TIMEOUT=8`, `pc` never 0x44 → `timeout=1` after the 8th edge. `pass=0`, `fail=0`.
- **Halt/timeout race:** `TIMEOUT=8`, `pc=0x44` and `gp=1` on exactly the 8th edge → `pass=1`, `timeout=0`.
- **Clear race:** in FAIL, assert `clear` on the same edge as `pc=0x44` with `gp=1` → state RUN, all flags 0. A halt on the following edge then gives `pass=1`.
- **Async reset:** assert `rst` mid-RUN between edges → outputs go to 0 immediately. With perf enabled, `pc` toggling 0x0/0x4 for 10 cycles after release gives `pc_change_count=10`.
